// File: rtl/sort_mem_server.sv
// sort_mem_server: host front-end and memory responder for one quick-sort engine.
// Loads an array from an input stream into an internal RAM, starts the sorter,
// serves the sorter's read/write port, then streams the sorted array out.
// Optional feature macro: SORT_MEM_ORDER_CHECK_EN (unload ascending-order monitor).
module sort_mem_server #(
    parameter int MM = 256,
    parameter int MN = 32,
    parameter int MW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MN-1:0] in_data,
    input  logic          in_last,
    output logic          qs_start,
    output logic [MW:0]   qs_num,
    input  logic          qs_done,
    input  logic          MemRd,
    input  logic [MW-1:0] MemRdAddr,
    output logic [MN-1:0] MemRdData,
    input  logic          MemWr,
    input  logic [MW-1:0] MemWrAddr,
    input  logic [MN-1:0] MemWrData,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MN-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          err_trunc,
    output logic          err_order
);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_START  = 2'd1;
    localparam logic [1:0] ST_SORT   = 2'd2;
    localparam logic [1:0] ST_UNLOAD = 2'd3;

    localparam logic [MW-1:0] CNT_MAX = MW'(MM - 1);
    localparam logic [MW-1:0] CNT_ONE = MW'(1);
    localparam logic [MW:0]   NUM_ONE = (MW + 1)'(1);

    // Array storage; deliberately not cleared by reset.
    logic [MN-1:0] mem [0:MM-1];

    logic [1:0]    state_q,     state_d;
    logic [MW-1:0] cnt_q,       cnt_d;
    logic [MW:0]   num_q,       num_d;
    logic [MW:0]   rd_idx_q,    rd_idx_d;
    logic          in_ready_q,  in_ready_d;
    logic          qs_start_q,  qs_start_d;
    logic          busy_q,      busy_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q,  out_last_d;
    logic [MN-1:0] out_data_q,  out_data_d;
    logic [MN-1:0] memrd_q,     memrd_d;
    logic          err_trunc_q, err_trunc_d;

    logic          mem_we_s;
    logic [MW-1:0] mem_waddr_s;
    logic [MN-1:0] mem_wdata_s;
    logic          accept_s;
    logic          ul_fire_s;

`ifdef SORT_MEM_ORDER_CHECK_EN
    logic          err_order_q, err_order_d;
    logic [MN-1:0] prev_q,      prev_d;
    logic          have_prev_q, have_prev_d;
`endif

    assign accept_s  = in_valid && in_ready_q && (state_q == ST_LOAD);
    assign ul_fire_s = out_valid_q && out_ready;

    // Next-state, RAM write-port selection and output register computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        num_d       = num_q;
        rd_idx_d    = rd_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        memrd_d     = memrd_q;
        err_trunc_d = err_trunc_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = cnt_q;
        mem_wdata_s = in_data;
`ifdef SORT_MEM_ORDER_CHECK_EN
        err_order_d = err_order_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (accept_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = cnt_q;
                    mem_wdata_s = in_data;
                    cnt_d       = cnt_q + CNT_ONE;
                    // A new array starts: sticky errors from the last one go away.
                    if (cnt_q == {MW{1'b0}}) begin
                        err_trunc_d = 1'b0;
`ifdef SORT_MEM_ORDER_CHECK_EN
                        err_order_d = 1'b0;
`endif
                    end else begin
                        err_trunc_d = err_trunc_q;
                    end
                    if (in_last || (cnt_q == CNT_MAX)) begin
                        num_d = {1'b0, cnt_q} + NUM_ONE;
                        cnt_d = {MW{1'b0}};
                        if (!in_last) begin
                            err_trunc_d = 1'b1;
                        end else begin
                            err_trunc_d = err_trunc_d;
                        end
                        // A one-word array is already sorted; bypass the sorter.
                        if (cnt_q == {MW{1'b0}}) begin
                            state_d     = ST_UNLOAD;
                            rd_idx_d    = {(MW + 1){1'b0}};
                            out_valid_d = 1'b0;
`ifdef SORT_MEM_ORDER_CHECK_EN
                            have_prev_d = 1'b0;
`endif
                        end else begin
                            state_d = ST_START;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_START: begin
                state_d = ST_SORT;
            end
            ST_SORT: begin
                if (MemWr) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = MemWrAddr;
                    mem_wdata_s = MemWrData;
                end else begin
                    mem_we_s    = 1'b0;
                end
                // Read samples the RAM before this cycle's write lands: old data wins.
                if (MemRd) begin
                    memrd_d = mem[MemRdAddr];
                end else begin
                    memrd_d = memrd_q;
                end
                if (qs_done) begin
                    state_d     = ST_UNLOAD;
                    rd_idx_d    = {(MW + 1){1'b0}};
                    out_valid_d = 1'b0;
`ifdef SORT_MEM_ORDER_CHECK_EN
                    have_prev_d = 1'b0;
`endif
                end else begin
                    state_d = ST_SORT;
                end
            end
            ST_UNLOAD: begin
                // Output register refills whenever it is empty or being drained.
                if (!out_valid_q || out_ready) begin
                    if (rd_idx_q < num_q) begin
                        out_data_d  = mem[rd_idx_q[MW-1:0]];
                        out_last_d  = (rd_idx_q == (num_q - NUM_ONE));
                        out_valid_d = 1'b1;
                        rd_idx_d    = rd_idx_q + NUM_ONE;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end else begin
                    out_valid_d = out_valid_q;
                end
                if (ul_fire_s) begin
`ifdef SORT_MEM_ORDER_CHECK_EN
                    if (have_prev_q && (out_data_q < prev_q)) begin
                        err_order_d = 1'b1;
                    end else begin
                        err_order_d = err_order_d;
                    end
                    prev_d      = out_data_q;
                    have_prev_d = 1'b1;
`endif
                    if (out_last_q) begin
                        state_d     = ST_LOAD;
                        cnt_d       = {MW{1'b0}};
                        out_valid_d = 1'b0;
                    end else begin
                        state_d = ST_UNLOAD;
                    end
                end else begin
                    state_d = ST_UNLOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        in_ready_d = (state_d == ST_LOAD);
        qs_start_d = (state_d == ST_START);
        busy_d     = (state_d != ST_LOAD);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            cnt_q       <= {MW{1'b0}};
            num_q       <= {(MW + 1){1'b0}};
            rd_idx_q    <= {(MW + 1){1'b0}};
            in_ready_q  <= 1'b0;
            qs_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= {MN{1'b0}};
            memrd_q     <= {MN{1'b0}};
            err_trunc_q <= 1'b0;
`ifdef SORT_MEM_ORDER_CHECK_EN
            err_order_q <= 1'b0;
            prev_q      <= {MN{1'b0}};
            have_prev_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            rd_idx_q    <= rd_idx_d;
            in_ready_q  <= in_ready_d;
            qs_start_q  <= qs_start_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            memrd_q     <= memrd_d;
            err_trunc_q <= err_trunc_d;
`ifdef SORT_MEM_ORDER_CHECK_EN
            err_order_q <= err_order_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
`endif
        end
    end

    // Single RAM write port shared by stream load and sorter writes.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign in_ready  = in_ready_q;
    assign qs_start  = qs_start_q;
    assign qs_num    = num_q;
    assign MemRdData = memrd_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign err_trunc = err_trunc_q;
`ifdef SORT_MEM_ORDER_CHECK_EN
    assign err_order = err_order_q;
`else
    assign err_order = 1'b0;
`endif

endmodule

// File: tb/tb_sort_mem_server.sv
// Directed self-checking bench for sort_mem_server with a behavioural sorter
// and an output scoreboard queue.
module tb_sort_mem_server;

    localparam int MM = 256;
    localparam int MN = 32;
    localparam int MW = 8;
`ifdef SORT_MEM_ORDER_CHECK_EN
    localparam logic ORD_EXP = 1'b1;
`else
    localparam logic ORD_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [MN-1:0] in_data;
    logic          in_last;
    logic          qs_start;
    logic [MW:0]   qs_num;
    logic          qs_done;
    logic          MemRd;
    logic [MW-1:0] MemRdAddr;
    logic [MN-1:0] MemRdData;
    logic          MemWr;
    logic [MW-1:0] MemWrAddr;
    logic [MN-1:0] MemWrData;
    logic          out_valid;
    logic          out_ready;
    logic [MN-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          err_trunc;
    logic          err_order;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb[$];
    logic [31:0] ld[$];

    sort_mem_server #(.MM(MM), .MN(MN), .MW(MW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .qs_start(qs_start), .qs_num(qs_num), .qs_done(qs_done),
        .MemRd(MemRd), .MemRdAddr(MemRdAddr), .MemRdData(MemRdData),
        .MemWr(MemWr), .MemWrAddr(MemWrAddr), .MemWrData(MemWrData),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_trunc(err_trunc), .err_order(err_order)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int k = 0; k < 50 && !done; k++) begin
            if (in_ready === 1'b1) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) chk("in_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic load_ld(input logic with_last);
        for (int i = 0; i < ld.size(); i++) send_word(ld[i], with_last && (i == ld.size() - 1));
    endtask

    task automatic expect_start(input logic [31:0] exp_num);
        bit seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (qs_start === 1'b1) seen = 1'b1;
            else tick();
        end
        chk("qs_start_seen", 32'(seen), 32'd1);
        chk("qs_num", 32'(qs_num), exp_num);
        tick();
        chk("qs_start_one_cycle", 32'(qs_start), 32'd0);
        chk("qs_num_hold", 32'(qs_num), exp_num);
    endtask

    task automatic mem_rd(input int a, output logic [31:0] d);
        MemRd = 1'b1;
        MemRdAddr = MW'(a);
        tick();
        MemRd = 1'b0;
        d = MemRdData;
    endtask

    task automatic mem_wr(input int a, input logic [31:0] d);
        MemWr = 1'b1;
        MemWrAddr = MW'(a);
        MemWrData = d;
        tick();
        MemWr = 1'b0;
    endtask

    task automatic sorter_done();
        qs_done = 1'b1;
        tick();
        qs_done = 1'b0;
    endtask

    task automatic drain(input int n, input bit toggle);
        int got = 0;
        int c = 0;
        bit held = 1'b0;
        logic [31:0] hd = 32'd0;
        logic hl = 1'b0;
        logic [31:0] e;
        while (got < n && c < n * 8 + 40) begin
            out_ready = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            if (held) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, hd);
                chk("hold_last", 32'(out_last), 32'(hl));
                held = 1'b0;
            end
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
                    chk("out_data", out_data, e);
                    chk("out_last", 32'(out_last), 32'(got == n - 1));
                    got++;
                end else begin
                    held = 1'b1;
                    hd = out_data;
                    hl = out_last;
                end
            end
            tick();
            c++;
        end
        out_ready = 1'b0;
        chk("drain_count", 32'(got), 32'(n));
        chk("out_valid_after", 32'(out_valid), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] arr[$];
        logic [31:0] tmp;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; qs_done = 1'b0;
        MemRd = 1'b0; MemRdAddr = '0; MemWr = 1'b0; MemWrAddr = '0; MemWrData = '0;
        out_ready = 1'b0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_qs_start", 32'(qs_start), 32'd0);
        chk("rst_qs_num", 32'(qs_num), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_memrd", MemRdData, 32'd0);
        chk("rst_err_trunc", 32'(err_trunc), 32'd0);
        chk("rst_err_order", 32'(err_order), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // {5,3,9,1} with a swap-only sorter -> 1,3,9,5
        ld = '{32'd5, 32'd3, 32'd9, 32'd1};
        load_ld(1'b1);
        chk("t1_busy", 32'(busy), 32'd1);
        expect_start(32'd4);
        chk("t1_sort_in_ready", 32'(in_ready), 32'd0);
        mem_rd(0, d); chk("t1_rd0", d, 32'd5);
        mem_rd(3, d); chk("t1_rd3", d, 32'd1);
        MemRd = 1'b1; MemRdAddr = 8'd1; MemWr = 1'b1; MemWrAddr = 8'd1; MemWrData = 32'hAA;
        tick();
        MemRd = 1'b0; MemWr = 1'b0;
        chk("t1_rw_old", MemRdData, 32'd3);
        mem_rd(1, d); chk("t1_rw_new", d, 32'hAA);
        mem_wr(1, 32'd3);
        mem_wr(0, 32'd1);
        mem_wr(3, 32'd5);
        chk("t1_rd_hold", MemRdData, 32'hAA);
        sorter_done();
        sb.push_back(32'd1); sb.push_back(32'd3); sb.push_back(32'd9); sb.push_back(32'd5);
        drain(4, 1'b0);
        chk("t1_err_order", 32'(err_order), 32'd0);

        // Single word: no sorter involvement
        send_word(32'd7, 1'b1);
        chk("t2_no_start", 32'(qs_start), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_qs_num", 32'(qs_num), 32'd1);
        sb.push_back(32'd7);
        drain(1, 1'b0);

        // Backpressure 1-0-0-1 on a 4-word array
        ld = '{32'd10, 32'd20, 32'd30, 32'd40};
        load_ld(1'b1);
        expect_start(32'd4);
        sorter_done();
        for (int i = 0; i < 4; i++) sb.push_back(ld[i]);
        drain(4, 1'b1);

        // 16 random words through a full behavioural sort
        ld.delete();
        for (int i = 0; i < 16; i++) ld.push_back($urandom);
        load_ld(1'b1);
        expect_start(32'd16);
        arr.delete();
        for (int i = 0; i < 16; i++) begin
            mem_rd(i, d);
            chk("t4_rd", d, ld[i]);
            arr.push_back(d);
        end
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 15 - i; j++)
                if (arr[j] > arr[j+1]) begin tmp = arr[j]; arr[j] = arr[j+1]; arr[j+1] = tmp; end
        for (int i = 0; i < 16; i++) mem_wr(i, arr[i]);
        sorter_done();
        arr = ld;
        arr.sort();
        for (int i = 0; i < 16; i++) sb.push_back(arr[i]);
        drain(16, 1'b0);
        chk("t4_err_order", 32'(err_order), 32'd0);

        // Truncation at MM words
        ld.delete();
        for (int i = 0; i < MM; i++) ld.push_back($urandom);
        load_ld(1'b0);
        chk("t5_in_ready", 32'(in_ready), 32'd0);
        chk("t5_err_trunc", 32'(err_trunc), 32'd1);
        expect_start(32'(MM));
        in_valid = 1'b1; in_data = 32'h1234;
        tick();
        chk("t5_stall", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        sorter_done();
        for (int i = 0; i < MM; i++) sb.push_back(ld[i]);
        drain(MM, 1'b0);
        chk("t5_trunc_sticky", 32'(err_trunc), 32'd1);

        // Unsorted RAM forced by the sorter
        send_word(32'd7, 1'b0);
        chk("t6_trunc_clr", 32'(err_trunc), 32'd0);
        send_word(32'd8, 1'b1);
        expect_start(32'd2);
        mem_wr(0, 32'd4);
        mem_wr(1, 32'd2);
        sorter_done();
        sb.push_back(32'd4); sb.push_back(32'd2);
        drain(2, 1'b0);
        chk("t6_err_order", 32'(err_order), 32'(ORD_EXP));

        // Reset in the middle of SORT; a later done is ignored
        send_word(32'd1, 1'b0);
        chk("t7_order_clr", 32'(err_order), 32'd0);
        send_word(32'd2, 1'b0);
        send_word(32'd3, 1'b1);
        expect_start(32'd3);
        chk("t7_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("t7_in_ready", 32'(in_ready), 32'd1);
        chk("t7_busy_rst", 32'(busy), 32'd0);
        chk("t7_qs_num", 32'(qs_num), 32'd0);
        sorter_done();
        tick();
        chk("t7_done_ignored", 32'(busy), 32'd0);
        chk("t7_no_out", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
